imem_loader: RTL and testbench

- Writer-side counterpart to the program counter: the PC generates instruction-memory read addresses, and this block generates the write addresses and data that fill instruction memory before execution.
- Accepts a framed byte stream over a valid/ready handshake and writes each payload byte into byte-addressed instruction memory.
- Verifies an 8-bit checksum at the end of the frame.
- Holds the CPU (PC and datapath) in reset until a load completes successfully.

---
 rtl/imem_loader.sv | 133 +++++++++++++
 tb/tb_imem_loader.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Instruction-memory loader: receives a length/payload/checksum byte frame and
// writes the payload into instruction memory while holding the CPU in reset.
module imem_loader #(
    parameter int                ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [8:0] len;
    logic [8:0] idx;
    logic [7:0] sum;
    logic       accept;
    logic       start_ok;
    logic       last_byte;

    assign accept    = in_valid && in_ready;
    assign start_ok  = start && (state == S_IDLE || state == S_DONE || state == S_ERR);
    assign last_byte = (idx == len - 9'd1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Abort outranks a byte offered in the same cycle.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) state_next = S_LEN;
            end
            S_LEN: begin
                if (abort)       state_next = S_ERR;
                else if (accept) state_next = S_DATA;
            end
            S_DATA: begin
                if (abort)                   state_next = S_ERR;
                else if (accept && last_byte) state_next = S_CSUM;
            end
            S_CSUM: begin
                if (abort)       state_next = S_ERR;
                else if (accept) state_next = (in_data == sum) ? S_DONE : S_ERR;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == S_LEN) || (state == S_DATA) || (state == S_CSUM);
    end

    // Length 0 encodes a full 256-byte payload.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 8'h00;
            cpu_hold  <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            len       <= 9'd0;
            idx       <= 9'd0;
            sum       <= 8'h00;
        end else begin
            mem_we <= 1'b0;
            if (start_ok) begin
                busy     <= 1'b1;
                cpu_hold <= 1'b1;
                done     <= 1'b0;
                err      <= 1'b0;
                idx      <= 9'd0;
                sum      <= 8'h00;
            end else if (in_ready && abort) begin
                busy     <= 1'b0;
                err      <= 1'b1;
                cpu_hold <= 1'b1;
            end else if (accept) begin
                case (state)
                    S_LEN: begin
                        len <= (in_data == 8'h00) ? 9'd256 : {1'b0, in_data};
                    end
                    S_DATA: begin
                        mem_we    <= 1'b1;
                        mem_addr  <= BASE_ADDR + ADDR_W'(idx);
                        mem_wdata <= in_data;
                        sum       <= sum + in_data;
                        idx       <= idx + 9'd1;
                    end
                    S_CSUM: begin
                        busy <= 1'b0;
                        if (in_data == sum) begin
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: a cycle-by-cycle vector table plus hand-built frames
// for wrap-around, 256-byte payloads, abort and mid-load reset.
module tb_imem_loader;

    typedef struct packed {
        logic       rdy;
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic       busy;
        logic       done;
        logic       err;
        logic       hold;
    } outs_t;

    typedef struct {
        logic  start;
        logic  abort;
        logic  valid;
        logic [7:0] data;
        outs_t exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;

    logic       in_ready, mem_we, cpu_hold, busy, done, err;
    logic [7:0] mem_addr, mem_wdata;
    logic       in_ready_fe, mem_we_fe, cpu_hold_fe, busy_fe, done_fe, err_fe;
    logic [7:0] mem_addr_fe, mem_wdata_fe;

    int checks = 0;
    int errors = 0;

    logic [7:0] log_a[$];
    logic [7:0] log_d[$];
    logic [7:0] log_a_fe[$];
    logic [7:0] log_d_fe[$];
    logic [7:0] payload[256];
    vec_t       vecs[19];

    imem_loader #(.ADDR_W(8), .BASE_ADDR(8'h00)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err)
    );

    imem_loader #(.ADDR_W(8), .BASE_ADDR(8'hFE)) dut_fe (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_fe),
        .mem_we(mem_we_fe), .mem_addr(mem_addr_fe), .mem_wdata(mem_wdata_fe),
        .cpu_hold(cpu_hold_fe), .busy(busy_fe), .done(done_fe), .err(err_fe)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we) begin
            log_a.push_back(mem_addr);
            log_d.push_back(mem_wdata);
        end
        if (mem_we_fe) begin
            log_a_fe.push_back(mem_addr_fe);
            log_d_fe.push_back(mem_wdata_fe);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: run did not finish, act=timeout req=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic outs_t actual();
        return '{in_ready, mem_we, mem_addr, mem_wdata, busy, done, err, cpu_hold};
    endfunction

    function automatic vec_t mkVec(input logic s, input logic a, input logic v,
                                   input logic [7:0] d, input outs_t e);
        vec_t r;
        r.start = s;
        r.abort = a;
        r.valid = v;
        r.data  = d;
        r.exp   = e;
        return r;
    endfunction

    task automatic checkOutput(input string name, input outs_t exp);
        outs_t act;
        act = actual();
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: act rdy=%b we=%b addr=%h wd=%h busy=%b done=%b err=%b hold=%b req rdy=%b we=%b addr=%h wd=%h busy=%b done=%b err=%b hold=%b",
                     name, act.rdy, act.we, act.addr, act.wdata, act.busy, act.done, act.err, act.hold,
                     exp.rdy, exp.we, exp.addr, exp.wdata, exp.busy, exp.done, exp.err, exp.hold);
        end
    endtask

    task automatic checkInt(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: act=%0d req=%0d", name, act, exp);
        end
    endtask

    task automatic checkLog(input string name, input bit fe, input int n, input logic [7:0] base);
        int bad;
        int sz;
        bad = 0;
        sz  = fe ? log_a_fe.size() : log_a.size();
        checkInt({name, "_count"}, sz, n);
        for (int k = 0; k < n && k < sz; k++) begin
            if (fe) begin
                if (log_a_fe[k] !== 8'(base + k) || log_d_fe[k] !== payload[k]) bad++;
            end else begin
                if (log_a[k] !== 8'(base + k) || log_d[k] !== payload[k]) bad++;
            end
        end
        checkInt({name, "_contents_bad"}, bad, 0);
    endtask

    task automatic applyStimulus(input logic s, input logic a, input logic v, input logic [7:0] d);
        @(negedge clk);
        start    = s;
        abort    = a;
        in_valid = v;
        in_data  = d;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic sendByte(input logic [7:0] b, input int gap);
        repeat (gap) idleCycle();
        applyStimulus(1'b0, 1'b0, 1'b1, b);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL in_ready_when_sending: act=%b req=1", in_ready);
        end
    endtask

    task automatic clearLogs();
        log_a.delete();
        log_d.delete();
        log_a_fe.delete();
        log_d_fe.delete();
    endtask

    task automatic runFrame(input logic [7:0] l, input int n, input logic [7:0] c, input bit gaps);
        clearLogs();
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        sendByte(l, 0);
        for (int k = 0; k < n; k++) sendByte(payload[k], gaps ? int'($urandom_range(0, 2)) : 0);
        sendByte(c, 0);
        idleCycle();
        idleCycle();
        idleCycle();
    endtask

    initial begin
        // Columns: rdy we addr wdata busy done err hold, observed just after the edge.
        vecs[0]  = mkVec(1, 0, 0, 8'h00, '{1, 0, 8'h00, 8'h00, 1, 0, 0, 1});
        vecs[1]  = mkVec(0, 0, 1, 8'h03, '{1, 0, 8'h00, 8'h00, 1, 0, 0, 1});
        vecs[2]  = mkVec(0, 0, 1, 8'h20, '{1, 1, 8'h00, 8'h20, 1, 0, 0, 1});
        vecs[3]  = mkVec(0, 0, 1, 8'h08, '{1, 1, 8'h01, 8'h08, 1, 0, 0, 1});
        vecs[4]  = mkVec(0, 0, 1, 8'h05, '{1, 1, 8'h02, 8'h05, 1, 0, 0, 1});
        vecs[5]  = mkVec(0, 0, 1, 8'h2D, '{0, 0, 8'h02, 8'h05, 0, 1, 0, 0});
        vecs[6]  = mkVec(0, 0, 0, 8'h00, '{0, 0, 8'h02, 8'h05, 0, 1, 0, 0});
        vecs[7]  = mkVec(0, 1, 0, 8'h00, '{0, 0, 8'h02, 8'h05, 0, 1, 0, 0});
        vecs[8]  = mkVec(1, 0, 0, 8'h00, '{1, 0, 8'h02, 8'h05, 1, 0, 0, 1});
        vecs[9]  = mkVec(0, 0, 1, 8'h03, '{1, 0, 8'h02, 8'h05, 1, 0, 0, 1});
        vecs[10] = mkVec(0, 0, 1, 8'h20, '{1, 1, 8'h00, 8'h20, 1, 0, 0, 1});
        vecs[11] = mkVec(1, 0, 0, 8'h00, '{1, 0, 8'h00, 8'h20, 1, 0, 0, 1});
        vecs[12] = mkVec(0, 0, 1, 8'h08, '{1, 1, 8'h01, 8'h08, 1, 0, 0, 1});
        vecs[13] = mkVec(0, 0, 0, 8'h00, '{1, 0, 8'h01, 8'h08, 1, 0, 0, 1});
        vecs[14] = mkVec(0, 0, 1, 8'h05, '{1, 1, 8'h02, 8'h05, 1, 0, 0, 1});
        vecs[15] = mkVec(0, 0, 1, 8'h2C, '{0, 0, 8'h02, 8'h05, 0, 0, 1, 1});
        vecs[16] = mkVec(0, 1, 0, 8'h00, '{0, 0, 8'h02, 8'h05, 0, 0, 1, 1});
        vecs[17] = mkVec(1, 1, 0, 8'h00, '{1, 0, 8'h02, 8'h05, 1, 0, 0, 1});
        vecs[18] = mkVec(0, 1, 0, 8'h00, '{0, 0, 8'h02, 8'h05, 0, 0, 1, 1});

        repeat (3) @(negedge clk);
        checkOutput("reset_state", '{0, 0, 8'h00, 8'h00, 0, 0, 0, 1});
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 19; i++) begin
            applyStimulus(vecs[i].start, vecs[i].abort, vecs[i].valid, vecs[i].data);
            @(posedge clk);
            #1;
            checkOutput($sformatf("vec%0d", i), vecs[i].exp);
        end
        idleCycle();

        // Wrap-around on the FE-based instance.
        payload[0] = 8'h01; payload[1] = 8'h02; payload[2] = 8'h03; payload[3] = 8'h04;
        runFrame(8'h04, 4, 8'h0A, 1'b0);
        checkLog("wrap_fe", 1'b1, 4, 8'hFE);
        checkInt("wrap_fe_status", int'({in_ready_fe, busy_fe, done_fe, err_fe, cpu_hold_fe}), int'(5'b00100));
        checkLog("wrap_base0", 1'b0, 4, 8'h00);

        // Full 256-byte payload, then again with random valid gaps.
        for (int k = 0; k < 256; k++) payload[k] = 8'(k);
        runFrame(8'h00, 256, 8'h80, 1'b0);
        checkLog("full256", 1'b0, 256, 8'h00);
        checkOutput("full256_done", '{0, 0, 8'hFF, 8'hFF, 0, 1, 0, 0});
        runFrame(8'h00, 256, 8'h80, 1'b1);
        checkLog("full256_gaps", 1'b0, 256, 8'h00);
        checkOutput("full256_gaps_done", '{0, 0, 8'hFF, 8'hFF, 0, 1, 0, 0});

        // Abort together with the third payload byte.
        payload[0] = 8'h11; payload[1] = 8'h22; payload[2] = 8'h33;
        clearLogs();
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        sendByte(8'h05, 0);
        sendByte(8'h11, 0);
        sendByte(8'h22, 0);
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h33);
        @(posedge clk);
        #1;
        checkOutput("abort_edge", '{0, 0, 8'h01, 8'h22, 0, 0, 1, 1});
        idleCycle();
        idleCycle();
        idleCycle();
        checkLog("abort", 1'b0, 2, 8'h00);

        payload[0] = 8'h20; payload[1] = 8'h08; payload[2] = 8'h05;
        runFrame(8'h03, 3, 8'h2D, 1'b0);
        checkLog("reload", 1'b0, 3, 8'h00);
        checkOutput("reload_done", '{0, 0, 8'h02, 8'h05, 0, 1, 0, 0});

        // Reset pulled mid-payload after two writes.
        clearLogs();
        payload[0] = 8'hA1; payload[1] = 8'hB2;
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        sendByte(8'h05, 0);
        sendByte(8'hA1, 0);
        sendByte(8'hB2, 0);
        idleCycle();
        #2;
        rst = 1'b0;
        #1;
        checkOutput("async_reset", '{0, 0, 8'h00, 8'h00, 0, 0, 0, 1});
        repeat (3) @(negedge clk);
        checkLog("reset_midload", 1'b0, 2, 8'h00);
        rst = 1'b1;

        payload[0] = 8'h20; payload[1] = 8'h08; payload[2] = 8'h05;
        runFrame(8'h03, 3, 8'h2D, 1'b0);
        checkLog("after_reset", 1'b0, 3, 8'h00);
        checkOutput("after_reset_done", '{0, 0, 8'h02, 8'h05, 0, 1, 0, 0});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
